// File: rtl/baccarat_task4.sv
// Single-player Baccarat engine: each KEY[0] press deals one card, and the hands, scores and winner are displayed.
// Optional build macro DEAL_LFSR_EN replaces the 1..13 wrap counter with a 7-bit LFSR card source.
//
// state  | meaning
// S_P1   | next step loads player card 1
// S_D1   | next step loads dealer card 1
// S_P2   | next step loads player card 2
// S_D2   | next step loads dealer card 2
// S_EVAL | next step applies the natural / third-card rules
// S_P3   | next step loads player card 3, then applies the dealer rule
// S_D3   | next step loads dealer card 3
// S_DONE | winner shown; steps ignored until reset
module baccarat_task4 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  typedef enum logic [2:0] {
    S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_D3, S_DONE
  } state_t;

  logic rst;
  logic unused_keys;
  assign rst         = KEY[3];
  assign unused_keys = ^KEY[2:1];

  logic [SYNC_STAGES-1:0] key_sync;
  logic                   key_prev;
  logic                   step;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      key_sync <= '0;
      key_prev <= 1'b0;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], KEY[0]};
      key_prev <= key_sync[SYNC_STAGES-1];
    end
  end

  assign step = key_sync[SYNC_STAGES-1] & ~key_prev;

  logic [3:0] card_src;

`ifdef DEAL_LFSR_EN
  logic [6:0] lfsr;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) lfsr <= 7'h01;
    else     lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  assign card_src = 4'(lfsr % 7'd13) + 4'd1;
`else
  logic [3:0] card_ctr;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst)                  card_ctr <= 4'd1;
    else if (card_ctr == 4'd13) card_ctr <= 4'd1;
    else                      card_ctr <= card_ctr + 4'd1;
  end

  assign card_src = card_ctr;
`endif

  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'd1:    return 7'b0001000;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      4'd10:   return 7'b1000000;
      4'd11:   return 7'b1100001;
      4'd12:   return 7'b0011000;
      4'd13:   return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  // Banker third-card table, indexed by dealer score and the player's third-card value.
  function automatic logic dealer_draws(input logic [3:0] d, input logic [3:0] p3);
    case (d)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return p3 != 4'd8;
      4'd4:             return p3 >= 4'd2 && p3 <= 4'd7;
      4'd5:             return p3 >= 4'd4 && p3 <= 4'd7;
      4'd6:             return p3 == 4'd6 || p3 == 4'd7;
      default:          return 1'b0;
    endcase
  endfunction

  logic [3:0] p_card [3];
  logic [3:0] d_card [3];
  logic [2:0] ld_p;
  logic [2:0] ld_d;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        p_card[i] <= 4'd0;
        d_card[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld_p[i]) p_card[i] <= card_src;
        if (ld_d[i]) d_card[i] <= card_src;
      end
    end
  end

  logic [4:0] p_sum;
  logic [4:0] d_sum;
  logic [3:0] p_score;
  logic [3:0] d_score;

  assign p_sum = 5'(card_value(p_card[0])) + 5'(card_value(p_card[1])) + 5'(card_value(p_card[2]));
  assign d_sum = 5'(card_value(d_card[0])) + 5'(card_value(d_card[1])) + 5'(card_value(d_card[2]));
  assign p_score = 4'(p_sum % 5'd10);
  assign d_score = 4'(d_sum % 5'd10);

  state_t state;
  state_t state_next;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= S_P1;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_p       = 3'b000;
    ld_d       = 3'b000;
    if (step) begin
      case (state)
        S_P1: begin ld_p[0] = 1'b1; state_next = S_D1;   end
        S_D1: begin ld_d[0] = 1'b1; state_next = S_P2;   end
        S_P2: begin ld_p[1] = 1'b1; state_next = S_D2;   end
        S_D2: begin ld_d[1] = 1'b1; state_next = S_EVAL; end
        S_EVAL: begin
          if (p_score >= 4'd8 || d_score >= 4'd8) state_next = S_DONE;
          else if (p_score <= 4'd5)               state_next = S_P3;
          else if (d_score <= 4'd5)               state_next = S_D3;
          else                                    state_next = S_DONE;
        end
        // The dealer decision uses the card being loaded on this same edge.
        S_P3: begin
          ld_p[2]    = 1'b1;
          state_next = dealer_draws(d_score, card_value(card_src)) ? S_D3 : S_DONE;
        end
        S_D3: begin ld_d[2] = 1'b1; state_next = S_DONE; end
        default: state_next = state;
      endcase
    end
  end

  logic done;
  assign done = (state == S_DONE);

  assign LEDR = {done && (d_score >= p_score), done && (p_score >= d_score), d_score, p_score};
  assign HEX0 = seg7(p_card[0]);
  assign HEX1 = seg7(p_card[1]);
  assign HEX2 = seg7(p_card[2]);
  assign HEX3 = seg7(d_card[0]);
  assign HEX4 = seg7(d_card[1]);
  assign HEX5 = seg7(d_card[2]);

endmodule

// File: tb/tb_baccarat_task4.sv
// Bench for baccarat_task4: directed and random games checked against a rule-level Baccarat model.
// Cards are predicted from the number of clock edges since reset release.
module tb_baccarat_task4;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int  pc [3];
  int  dc [3];
  bit  done;
  logic [6:0] seg_tab [16];

  always #10 clk = ~clk;

  baccarat_task4 #(.SYNC_STAGES(2)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .LEDR    (ledr),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2),
    .HEX3    (hex3),
    .HEX4    (hex4),
    .HEX5    (hex5)
  );

  always @(posedge clk or posedge key[3]) begin
    if (key[3]) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int pscore();
    return (val(pc[0]) + val(pc[1]) + val(pc[2])) % 10;
  endfunction

  function automatic int dscore();
    return (val(dc[0]) + val(dc[1]) + val(dc[2])) % 10;
  endfunction

  function automatic bit banker_draws(input int d, input int p3);
    if (d <= 2) return 1'b1;
    if (d == 3) return p3 != 8;
    if (d == 4) return p3 inside {[2:7]};
    if (d == 5) return p3 inside {[4:7]};
    if (d == 6) return p3 inside {6, 7};
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int p, d;
    p = pscore();
    d = dscore();
    chk({tag, " HEX0"}, {3'b0, hex0}, {3'b0, seg_tab[pc[0]]});
    chk({tag, " HEX1"}, {3'b0, hex1}, {3'b0, seg_tab[pc[1]]});
    chk({tag, " HEX2"}, {3'b0, hex2}, {3'b0, seg_tab[pc[2]]});
    chk({tag, " HEX3"}, {3'b0, hex3}, {3'b0, seg_tab[dc[0]]});
    chk({tag, " HEX4"}, {3'b0, hex4}, {3'b0, seg_tab[dc[1]]});
    chk({tag, " HEX5"}, {3'b0, hex5}, {3'b0, seg_tab[dc[2]]});
    chk({tag, " LEDR"}, ledr, {done && d >= p, done && p >= d, 4'(d), 4'(p)});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      pc[i] = 0;
      dc[i] = 0;
    end
    done = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    key[0] = 1'b0;
    #3 key[3] = 1'b1;
    model_clear();
    #1 check_all({tag, " reset"});
    repeat (3) @(negedge clk);
    key[3] = 1'b0;
  endtask

  // Presses KEY[0]; target 0 means an arbitrary card, otherwise waits for that card to come up.
  task automatic do_step(input int target, output int card);
    int guard;
    key[0] = 1'b0;
    repeat (4) @(negedge clk);
    if (target == 0) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end else begin
      guard = 0;
      while ((((cyc + 2) % 13) + 1) != target && guard < 30) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 30) begin
        checks++;
        errors++;
        $error("FAIL card_align: observed no alignment, expected card %0d", target);
      end
    end
    key[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 card = (cyc % 13) + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic play_game(input string name, input int t [6]);
    int c, p, d;
    bit p_draw, d_draw;
    p_draw = 1'b0;
    d_draw = 1'b0;
    do_step(t[0], c); pc[0] = c; check_all({name, " p1"});
    do_step(t[1], c); dc[0] = c; check_all({name, " d1"});
    do_step(t[2], c); pc[1] = c; check_all({name, " p2"});
    do_step(t[3], c); dc[1] = c; check_all({name, " d2"});
    p = pscore();
    d = dscore();
    do_step(0, c);
    if (p >= 8 || d >= 8) done = 1'b1;
    else if (p <= 5)      p_draw = 1'b1;
    else if (d <= 5)      d_draw = 1'b1;
    else                  done = 1'b1;
    check_all({name, " eval"});
    if (p_draw) begin
      do_step(t[4], c);
      pc[2] = c;
      if (banker_draws(d, val(c))) d_draw = 1'b1;
      else                         done = 1'b1;
      check_all({name, " p3"});
    end
    if (d_draw) begin
      do_step(t[5], c);
      dc[2] = c;
      done = 1'b1;
      check_all({name, " d3"});
    end
    do_step(0, c);
    check_all({name, " ignored"});
  endtask

  initial begin
    int c;
    seg_tab = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};
    key = 4'b1000;
    model_clear();
    #35 check_all("hold_reset");
    @(negedge clk);
    key[3] = 1'b0;
    repeat (20) @(negedge clk);
    check_all("idle");

    play_game("p6_vs_d7", '{1, 13, 5, 7, 0, 0});
    do_reset("g2");
    play_game("natural8", '{4, 3, 4, 2, 0, 0});
    do_reset("g3");
    play_game("d3_p3_is_8", '{2, 3, 2, 13, 8, 0});
    do_reset("g4");
    play_game("tie7", '{3, 2, 4, 5, 0, 0});
    do_reset("g5");
    play_game("dealer_only", '{3, 2, 4, 2, 0, 0});
    do_reset("g6");
    play_game("both_draw", '{1, 10, 2, 2, 0, 0});

    for (int g = 0; g < 8; g++) begin
      do_reset("rnd");
      play_game($sformatf("rnd%0d", g), '{0, 0, 0, 0, 0, 0});
    end

    do_reset("mid");
    do_step(0, c); pc[0] = c;
    do_step(0, c); dc[0] = c;
    do_step(0, c); pc[1] = c;
    check_all("mid three_cards");
    do_reset("mid_deal");
    do_step(0, c); pc[0] = c;
    check_all("redeal p1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
